// File: rtl/mcyc_ctrl_fsm.sv
// Multicycle ARM main control FSM with memory wait states, MDU multiply
// handshake with watchdog, and a sticky illegal-instruction/timeout trap.
module mcyc_ctrl_fsm #(
    parameter bit MEM_WAIT   = 1'b1,
    parameter int MD_TIMEOUT = 64,
    parameter int TO_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] MulFunct,
    input  logic       MemReady,
    input  logic       MdDone,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       MdStart,
    output logic       MdAcc,
    output logic       Trap,
    output logic [3:0] State
);

    // state     | meaning
    // FETCH     | instruction fetch, PC+4; waits on MemReady
    // DECODE    | register read, dispatch on Op/Funct/MulFunct
    // MEMADR    | load/store address compute
    // MEMRD     | load data read; waits on MemReady
    // MEMWB     | load result to register file
    // MEMWR     | store; waits on MemReady
    // EXECUTER  | data-processing, register operand
    // EXECUTEI  | data-processing, immediate operand
    // ALUWB     | ALU result to register file
    // BRANCH    | branch target compute
    // TRAP      | illegal op or MDU timeout; left only by reset
    // MULSTART  | one-cycle MDU start pulse
    // MULWAIT   | waiting for MdDone, watchdog running
    // MULWB     | MDU result to register file
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10,
        S_MULSTART = 4'd11,
        S_MULWAIT  = 4'd12,
        S_MULWB    = 4'd13
    } state_t;

    typedef struct packed {
        logic       ir_nextpc;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       md_start;
        logic       trap;
    } ctrl_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MD_TIMEOUT > 0) ? MD_TIMEOUT - 1 : 0);

    state_t          state;
    state_t          nxt;
    ctrl_t           ctrl_q;
    logic [TO_W-1:0] to_cnt;
    logic            md_acc_q;
    logic            mem_rdy;
    logic            to_hit;
    logic            is_mul;
    logic            unused_funct;

    assign unused_funct = ^Funct[3:2];

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_nextpc  = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                c.result_src = 2'b10;
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
            end
            S_MEMADR:   c.alu_src_b = 2'b01;
            S_MEMRD:    c.adr_src = 1'b1;
            S_MEMWB: begin
                c.reg_w      = 1'b1;
                c.result_src = 2'b01;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_EXECUTER: c.alu_op = 1'b1;
            S_EXECUTEI: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            S_ALUWB:    c.reg_w = 1'b1;
            S_BRANCH: begin
                c.branch     = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b01;
            end
            S_MULSTART: c.md_start = 1'b1;
            S_MULWAIT:  c = '0;
            S_MULWB: begin
                c.reg_w      = 1'b1;
                c.result_src = 2'b11;
            end
            default:    c.trap = 1'b1;
        endcase
        return c;
    endfunction

    assign mem_rdy = MEM_WAIT ? MemReady : 1'b1;
    assign to_hit  = (MD_TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign is_mul  = (Op == 2'b00) && (Funct[5:4] == 2'b00) && (MulFunct == 4'b1001);

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    nxt = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00: begin
                        if (is_mul)        nxt = S_MULSTART;
                        else if (Funct[5]) nxt = S_EXECUTEI;
                        else               nxt = S_EXECUTER;
                    end
                    2'b01:   nxt = S_MEMADR;
                    2'b10:   nxt = S_BRANCH;
                    default: nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    nxt = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWR:    nxt = mem_rdy ? S_FETCH : S_MEMWR;
            S_EXECUTER: nxt = S_ALUWB;
            S_EXECUTEI: nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            S_MULSTART: nxt = S_MULWAIT;
            // a completion in the same cycle as the timeout is still accepted
            S_MULWAIT: begin
                if (MdDone)      nxt = S_MULWB;
                else if (to_hit) nxt = S_TRAP;
                else             nxt = S_MULWAIT;
            end
            S_MULWB:    nxt = S_FETCH;
            default:    nxt = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            ctrl_q   <= decode_ctrl(S_FETCH);
            to_cnt   <= '0;
            md_acc_q <= 1'b0;
        end else begin
            state  <= nxt;
            ctrl_q <= decode_ctrl(nxt);
            if (state == S_DECODE && nxt == S_MULSTART)
                md_acc_q <= Funct[1];
            if (state == S_MULSTART)
                to_cnt <= '0;
            else if (state == S_MULWAIT)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign IRWrite   = ctrl_q.ir_nextpc & mem_rdy;
    assign NextPC    = ctrl_q.ir_nextpc & mem_rdy;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ResultSrc = ctrl_q.result_src;
    assign RegW      = ctrl_q.reg_w;
    assign MemW      = ctrl_q.mem_w;
    assign Branch    = ctrl_q.branch;
    assign ALUOp     = ctrl_q.alu_op;
    assign MdStart   = ctrl_q.md_start;
    assign MdAcc     = ctrl_q.md_start & md_acc_q;
    assign Trap      = ctrl_q.trap;
    assign State     = state;

endmodule

// File: tb/tb_mcyc_ctrl_fsm.sv
// Self-checking bench for mcyc_ctrl_fsm: per-cycle expected state and
// control outputs are queued as stimulus is applied and compared mid-cycle.
module tb_mcyc_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] MulFunct;
    logic       MemReady;
    logic       MdDone;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
    logic       MdStart, MdAcc, Trap;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;
    logic [15:0] ctl_vec;

    int    n_chk  = 0;
    int    n_fail = 0;
    string cur    = "init";

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
    } exp_t;
    exp_t sb[$];

    mcyc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulFunct(MulFunct),
        .MemReady(MemReady), .MdDone(MdDone), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .MdStart(MdStart),
        .MdAcc(MdAcc), .Trap(Trap), .State(State)
    );

    assign ctl_vec = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                      RegW, MemW, Branch, ALUOp, MdStart, MdAcc, Trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control outputs for a state, straight from the output table.
    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr, input logic acc);
        logic ir, npc, adr, rw, mw, br, aop, mds, mda, trp;
        logic [1:0] sa, sb_, rs;
        {ir, npc, adr, rw, mw, br, aop, mds, mda, trp} = '0;
        sa = 2'b00; sb_ = 2'b00; rs = 2'b00;
        case (st)
            4'd0:  begin ir = mr; npc = mr; rs = 2'b10; sa = 2'b01; sb_ = 2'b10; end
            4'd1:  begin rs = 2'b10; sa = 2'b01; sb_ = 2'b10; end
            4'd2:  sb_ = 2'b01;
            4'd3:  adr = 1'b1;
            4'd4:  begin rw = 1'b1; rs = 2'b01; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  aop = 1'b1;
            4'd7:  begin sb_ = 2'b01; aop = 1'b1; end
            4'd8:  rw = 1'b1;
            4'd9:  begin br = 1'b1; rs = 2'b10; sb_ = 2'b01; end
            4'd10: trp = 1'b1;
            4'd11: begin mds = 1'b1; mda = acc; end
            4'd13: begin rw = 1'b1; rs = 2'b11; end
            default: ;
        endcase
        return {ir, npc, adr, sa, sb_, rs, rw, mw, br, aop, mds, mda, trp};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; checks at posedge+4 and returns at the next posedge+1.
    task automatic cyc(input logic mr, input logic mdd, input logic [3:0] est, input logic acc);
        exp_t e;
        MemReady = mr;
        MdDone   = mdd;
        e.st  = est;
        e.ctl = exp_ctl(est, mr, acc);
        sb.push_back(e);
        #3;
        e = sb.pop_front();
        check_eq({cur, ".state"}, {12'd0, State}, {12'd0, e.st});
        check_eq({cur, ".ctl"}, ctl_vec, e.ctl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq({cur, ".rst_state"}, {12'd0, State}, 16'd0);
        check_eq({cur, ".rst_mdstart"}, {15'd0, MdStart}, 16'd0);
        check_eq({cur, ".rst_trap"}, {15'd0, Trap}, 16'd0);
        check_eq({cur, ".rst_ctl"}, ctl_vec, exp_ctl(4'd0, MemReady, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] mf);
        Op = op; Funct = fn; MulFunct = mf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; MemReady = 1'b0; MdDone = 1'b0;
        set_instr(2'b00, 6'd0, 4'd0);

        cur = "por";
        do_reset();

        // LDR with two wait cycles in MEMRD; trailing FETCH without MemReady
        cur = "ldr";
        set_instr(2'b01, 6'b011001, 4'd0);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd2, 0);
        cyc(0, 0, 4'd3, 0); cyc(0, 0, 4'd3, 0); cyc(1, 0, 4'd3, 0);
        cyc(1, 0, 4'd4, 0); cyc(0, 0, 4'd0, 0);

        cur = "str";
        set_instr(2'b01, 6'b011000, 4'd0);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd2, 0);
        cyc(0, 0, 4'd5, 0); cyc(0, 0, 4'd5, 0); cyc(0, 0, 4'd5, 0);
        cyc(1, 0, 4'd5, 0);

        // MLA: MdDone during MULSTART must be ignored, done after 5 wait cycles
        cur = "mla";
        set_instr(2'b00, 6'b000010, 4'b1001);
        cyc(1, 0, 4'd0, 1); cyc(1, 0, 4'd1, 1); cyc(1, 1, 4'd11, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'd12, 1);
        cyc(1, 1, 4'd12, 1);
        cyc(1, 0, 4'd13, 1);

        // MUL completing on the last watchdog cycle
        cur = "mul_edge";
        set_instr(2'b00, 6'b000000, 4'b1001);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd11, 0);
        for (int i = 0; i < 63; i++) cyc(1, 0, 4'd12, 0);
        cyc(1, 1, 4'd12, 0);
        cyc(1, 0, 4'd13, 0);

        cur = "exei";
        set_instr(2'b00, 6'b101000, 4'b1001);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd7, 0); cyc(1, 0, 4'd8, 0);

        cur = "exer";
        set_instr(2'b00, 6'b000100, 4'b0000);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd6, 0); cyc(1, 0, 4'd8, 0);

        cur = "branch";
        set_instr(2'b10, 6'b000000, 4'b0000);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd9, 0);

        // MUL timeout: 64 MULWAIT cycles, then sticky TRAP
        cur = "mul_to";
        set_instr(2'b00, 6'b000000, 4'b1001);
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd11, 0);
        for (int i = 0; i < 64; i++) cyc(1, 0, 4'd12, 0);
        for (int i = 0; i < 5; i++) cyc(1, i[0], 4'd10, 0);
        cur = "rst_trap";
        do_reset();

        // reset asserted mid-MULWAIT
        cur = "rst_mul";
        cyc(1, 0, 4'd0, 0); cyc(1, 0, 4'd1, 0); cyc(1, 0, 4'd11, 0);
        cyc(1, 0, 4'd12, 0); cyc(1, 0, 4'd12, 0);
        do_reset();
        cyc(1, 0, 4'd0, 0);

        cur = "illegal";
        set_instr(2'b11, 6'b000000, 4'b0000);
        cyc(1, 0, 4'd1, 0);
        for (int i = 0; i < 21; i++) cyc(i[1], 0, 4'd10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
